// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick generator.
package clk_gen_pkg;

    // System clock frequency the divider values are expressed against.
    localparam int unsigned CLK_FREQ     = 50_000_000;

    // Power-up period and high time: 1 kHz square wave at 50 MHz.
    localparam int unsigned CLK_DEF_DIV  = 50_000;
    localparam int unsigned CLK_DEF_HIGH = 25_000;

    // What a channel does on a given cycle, in priority order.
    typedef enum logic [1:0] {
        CH_SYNC  = 2'd0,  // common phase-alignment restart
        CH_IDLE  = 2'd1,  // disabled or period of zero: parked at count 0
        CH_WRAP  = 2'd2,  // last count of the period: start a new one
        CH_COUNT = 2'd3   // mid-period increment
    } ch_action_e;

    // Period in clk cycles for a requested output frequency in Hz.
    // A request of 0 Hz returns 0, which parks the channel.
    function automatic int unsigned freq_to_div(input int unsigned freq);
        if (freq == 0) begin
            return 0;
        end
        return CLK_FREQ / freq;
    endfunction

endpackage

// File: rtl/clk_gen_multi_channel.sv
// One divider channel: shadow/active period and high time, the period
// counter, and registered clk_out / tick / upd_pending outputs.
// Shadow values only move into the active set at a period boundary
// (wrap), on sync, or while the channel is parked, so the output never
// changes width inside a running period.
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned DEF_DIV  = CLK_DEF_DIV,
    parameter int unsigned DEF_HIGH = CLK_DEF_HIGH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_div_i,
    input  logic [W-1:0] wr_high_i,
    output logic         clk_out_o,
    output logic         tick_o,
    output logic         upd_pending_o
);

    localparam logic [W-1:0] RST_DIV  = W'(DEF_DIV);
    localparam logic [W-1:0] RST_HIGH = W'(DEF_HIGH);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] shadow_div_q,  shadow_div_d;
    logic [W-1:0] shadow_high_q, shadow_high_d;
    logic [W-1:0] active_div_q,  active_div_d;
    logic [W-1:0] active_high_q, active_high_d;
    logic [W-1:0] cnt_q,         cnt_d;
    logic         clk_out_q,     clk_out_d;
    logic         tick_q,        tick_d;
    logic         pend_q,        pend_d;

    ch_action_e   action;

    // Pick this cycle's action: sync beats disable/park, which beats wrap.
    always_comb begin
        action = CH_COUNT;
        if (sync_i) begin
            action = CH_SYNC;
        end else if (!en_i || (active_div_q == '0)) begin
            action = CH_IDLE;
        end else if (cnt_q == (active_div_q - ONE)) begin
            action = CH_WRAP;
        end
    end

    // Next-state for shadows, active set, counter and outputs.
    // On every path that reloads the active set, the reload takes the
    // shadow as it was before this cycle's write; a same-cycle write stays
    // pending for the next boundary.
    always_comb begin
        shadow_div_d  = shadow_div_q;
        shadow_high_d = shadow_high_q;
        active_div_d  = active_div_q;
        active_high_d = active_high_q;
        cnt_d         = cnt_q;
        clk_out_d     = 1'b0;
        tick_d        = 1'b0;
        pend_d        = pend_q;

        if (wr_i) begin
            shadow_div_d  = wr_div_i;
            shadow_high_d = wr_high_i;
        end

        unique case (action)
            CH_SYNC: begin
                active_div_d  = shadow_div_q;
                active_high_d = shadow_high_q;
                cnt_d         = '0;
                pend_d        = wr_i;
                tick_d        = en_i;
                clk_out_d     = en_i && (shadow_high_q != '0);
            end
            CH_IDLE: begin
                active_div_d  = shadow_div_q;
                active_high_d = shadow_high_q;
                cnt_d         = '0;
                pend_d        = wr_i;
            end
            CH_WRAP: begin
                active_div_d  = shadow_div_q;
                active_high_d = shadow_high_q;
                cnt_d         = '0;
                pend_d        = wr_i;
                tick_d        = 1'b1;
                clk_out_d     = (shadow_high_q != '0);
            end
            default: begin
                cnt_d         = cnt_q + ONE;
                pend_d        = pend_q | wr_i;
                clk_out_d     = (cnt_d < active_high_q);
            end
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_div_q  <= RST_DIV;
            shadow_high_q <= RST_HIGH;
            active_div_q  <= RST_DIV;
            active_high_q <= RST_HIGH;
            cnt_q         <= '0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            shadow_div_q  <= shadow_div_d;
            shadow_high_q <= shadow_high_d;
            active_div_q  <= active_div_d;
            active_high_q <= active_high_d;
            cnt_q         <= cnt_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            pend_q        <= pend_d;
        end
    end

    assign clk_out_o     = clk_out_q;
    assign tick_o        = tick_q;
    assign upd_pending_o = pend_q;

endmodule

// File: rtl/clk_gen_multi.sv
// N-channel programmable clock/tick generator. Decodes the shared write
// port to a single channel and fans the common sync out to all channels.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned W        = 32,
    parameter int unsigned DEF_DIV  = CLK_DEF_DIV,
    parameter int unsigned DEF_HIGH = CLK_DEF_HIGH,
    localparam int unsigned CW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  en_i,
    input  logic          sync_i,
    input  logic          wr_en_i,
    input  logic [CW-1:0] wr_ch_i,
    input  logic [W-1:0]  wr_div_i,
    input  logic [W-1:0]  wr_high_i,
    output logic [N-1:0]  clk_out_o,
    output logic [N-1:0]  tick_o,
    output logic [N-1:0]  upd_pending_o
);

    logic [N-1:0] wr_sel;

    // One-hot write select; channel numbers with no instance match nothing.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            wr_sel[i] = wr_en_i && (wr_ch_i == CW'(i));
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_ch
        clk_gen_channel #(
            .W        (W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .en_i          (en_i[g]),
            .sync_i        (sync_i),
            .wr_i          (wr_sel[g]),
            .wr_div_i      (wr_div_i),
            .wr_high_i     (wr_high_i),
            .clk_out_o     (clk_out_o[g]),
            .tick_o        (tick_o[g]),
            .upd_pending_o (upd_pending_o[g])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi with N=2, W=8, reset period 4, high 2.
module tb_clk_gen_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] en = 2'b00;
    logic       sync = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_ch = 1'b0;
    logic [7:0] wr_div = 8'd0;
    logic [7:0] wr_high = 8'd0;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] upd_pending;

    int vectors = 0;
    int miscompares = 0;

    clk_gen_multi #(
        .N        (2),
        .W        (8),
        .DEF_DIV  (4),
        .DEF_HIGH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .sync_i        (sync),
        .wr_en_i       (wr_en),
        .wr_ch_i       (wr_ch),
        .wr_div_i      (wr_div),
        .wr_high_i     (wr_high),
        .clk_out_o     (clk_out),
        .tick_o        (tick),
        .upd_pending_o (upd_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge, sample point is 1 time unit after the edge.
    // Write and sync strobes last exactly one edge.
    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic do_write(input logic ch, input logic [7:0] div, input logic [7:0] high);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = div;
        wr_high = high;
    endtask

    // After this returns, the next posedge is "edge 1" with all counters at 0.
    task automatic apply_reset(input logic [1:0] en_v);
        wr_en = 1'b0;
        sync  = 1'b0;
        en    = en_v;
        rst   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] clk_pat;
        logic [7:0] tick_pat;
        logic [1:0] exp_c, exp_t;
        clk_pat  = 8'b1001_1001;
        tick_pat = 8'b1000_1000;
        en = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({clk_out, tick, upd_pending} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b required %b", {clk_out, tick, upd_pending}, 6'b0);
            miscompares++;
        end
        apply_reset(2'b11);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_c = {2{clk_pat[k-1]}};
            exp_t = {2{tick_pat[k-1]}};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL reset_pattern edge %0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_write_mid();
        logic [1:0] exp_c, exp_t;
        apply_reset(2'b11);
        step();                     // edge 1, cnt=1
        do_write(1'b1, 8'd6, 8'd1);
        step();                     // edge 2
        vectors++;
        if (upd_pending !== 2'b10) begin
            $display("FAIL write_mid_pending: got %b required %b", upd_pending, 2'b10);
            miscompares++;
        end
        step();                     // edge 3, old period still running
        vectors++;
        if (upd_pending !== 2'b10 || clk_out !== 2'b00) begin
            $display("FAIL write_mid_hold: got pend=%b clk_out=%b required pend=10 clk_out=00",
                     upd_pending, clk_out);
            miscompares++;
        end
        step();                     // edge 4, wrap applies 6/1 on ch1
        vectors++;
        if (upd_pending !== 2'b00) begin
            $display("FAIL write_mid_clear: got %b required %b", upd_pending, 2'b00);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            exp_c = {(k % 6 < 1), (k % 4 < 2)};
            exp_t = {(k % 6 == 0), (k % 4 == 0)};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL write_mid_period k=%0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_write_at_wrap();
        logic [7:0] clk_pat;
        logic [7:0] tick_pat;
        logic [1:0] exp_c, exp_t;
        clk_pat  = 8'b1011_0011;
        tick_pat = 8'b1001_0001;
        apply_reset(2'b11);
        step();
        step();
        step();                     // edge 3, ch0 at last count
        do_write(1'b0, 8'd3, 8'd2);
        step();                     // edge 4, wrap loads old 4/2
        vectors++;
        if (upd_pending !== 2'b01 || tick !== 2'b11) begin
            $display("FAIL wrap_write_edge: got pend=%b tick=%b required pend=01 tick=11", upd_pending, tick);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            exp_c = {(k % 4 < 2), clk_pat[k]};
            exp_t = {(k % 4 == 0), tick_pat[k]};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL wrap_write_period k=%0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
            if (k == 3) begin
                vectors++;
                if (upd_pending[0] !== 1'b1) begin
                    $display("FAIL wrap_write_pending: got %b required 1", upd_pending[0]);
                    miscompares++;
                end
            end
            if (k == 4) begin
                vectors++;
                if (upd_pending[0] !== 1'b0) begin
                    $display("FAIL wrap_write_applied: got %b required 0", upd_pending[0]);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_duty_extremes();
        logic [1:0] exp_t;
        apply_reset(2'b11);
        do_write(1'b0, 8'd4, 8'd0);
        step();
        do_write(1'b1, 8'd4, 8'd9);
        step();
        step();
        step();                     // edge 4, both channels pick up new duty
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            exp_t = (k % 4 == 0) ? 2'b11 : 2'b00;
            vectors++;
            if (clk_out !== 2'b10 || tick !== exp_t) begin
                $display("FAIL duty_extremes k=%0d: got clk_out=%b tick=%b required clk_out=10 tick=%b",
                         k, clk_out, tick, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_div_edge();
        logic [9:0] clk_pat;
        logic [9:0] tick_pat;
        logic [1:0] exp_c, exp_t;
        clk_pat  = 10'b10_0011_0001;
        tick_pat = 10'b10_0001_0000;
        apply_reset(2'b11);
        do_write(1'b0, 8'd1, 8'd1);
        step();
        do_write(1'b1, 8'd0, 8'd2);
        step();
        step();
        step();                     // edge 4, ch0 -> div 1, ch1 -> div 0
        for (int k = 5; k <= 8; k++) begin
            step();
            vectors++;
            if (clk_out !== 2'b01 || tick !== 2'b01) begin
                $display("FAIL div1_div0 edge %0d: got clk_out=%b tick=%b required clk_out=01 tick=01",
                         k, clk_out, tick);
                miscompares++;
            end
        end
        do_write(1'b1, 8'd5, 8'd2);
        step();                     // edge 9
        vectors++;
        if (upd_pending[1] !== 1'b1 || clk_out !== 2'b01 || tick !== 2'b01) begin
            $display("FAIL div0_write: got pend=%b clk_out=%b tick=%b required pend1=1 clk_out=01 tick=01",
                     upd_pending, clk_out, tick);
            miscompares++;
        end
        step();                     // edge 10
        vectors++;
        if (upd_pending[1] !== 1'b0 || clk_out !== 2'b01) begin
            $display("FAIL div0_load: got pend=%b clk_out=%b required pend1=0 clk_out=01", upd_pending, clk_out);
            miscompares++;
        end
        for (int k = 0; k < 10; k++) begin
            step();                 // edges 11..20
            exp_c = {clk_pat[k], 1'b1};
            exp_t = {tick_pat[k], 1'b1};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL div0_restart k=%0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_sync();
        logic [1:0] exp_c, exp_t;
        apply_reset(2'b11);
        do_write(1'b1, 8'd6, 8'd3);
        for (int k = 1; k <= 5; k++) step();
        sync = 1'b1;
        step();                     // edge 6, both restart at count 0
        for (int k = 0; k < 13; k++) begin
            if (k > 0) step();
            exp_c = {(k % 6 < 3), (k % 4 < 2)};
            exp_t = {(k % 6 == 0), (k % 4 == 0)};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL sync_align k=%0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] clk_pat;
        logic [7:0] tick_pat;
        logic [1:0] exp_c, exp_t;
        clk_pat  = 8'b1001_1001;
        tick_pat = 8'b1000_1000;
        apply_reset(2'b11);
        do_write(1'b1, 8'd6, 8'd1);
        step();                     // edge 1
        vectors++;
        if (upd_pending !== 2'b10 || clk_out !== 2'b11) begin
            $display("FAIL rst_mid_pre: got pend=%b clk_out=%b required pend=10 clk_out=11", upd_pending, clk_out);
            miscompares++;
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({clk_out, tick, upd_pending} !== 6'b0) begin
            $display("FAIL rst_mid_async: got %b required %b", {clk_out, tick, upd_pending}, 6'b0);
            miscompares++;
        end
        apply_reset(2'b11);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_c = {2{clk_pat[k-1]}};
            exp_t = {2{tick_pat[k-1]}};
            vectors++;
            if (clk_out !== exp_c || tick !== exp_t) begin
                $display("FAIL rst_mid_defaults edge %0d: got clk_out=%b tick=%b required clk_out=%b tick=%b",
                         k, clk_out, tick, exp_c, exp_t);
                miscompares++;
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] tick_pat;
        tick_pat = 4'b1000;
        apply_reset(2'b11);
        step();                     // edge 1
        en = 2'b10;
        for (int k = 2; k <= 4; k++) begin
            step();
            vectors++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                $display("FAIL disable edge %0d: got clk_out0=%b tick0=%b required 0 0", k, clk_out[0], tick[0]);
                miscompares++;
            end
        end
        vectors++;
        if (tick !== 2'b10) begin
            $display("FAIL disable_other: got tick=%b required 10", tick);
            miscompares++;
        end
        en = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();                 // edges 5..8
            vectors++;
            if (tick[0] !== tick_pat[k]) begin
                $display("FAIL reenable k=%0d: got tick0=%b required %b", k, tick[0], tick_pat[k]);
                miscompares++;
            end
        end
        vectors++;
        if (tick !== 2'b11) begin
            $display("FAIL reenable_both: got tick=%b required 11", tick);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_write_mid();
        test_write_at_wrap();
        test_duty_extremes();
        test_div_edge();
        test_sync();
        test_rst_mid();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_gen_multi.md
# clk_gen_multi

Multi-channel programmable clock/tick generator replacing fixed-frequency dividers in the accelerometer and arm-control datapath. Each of N channels divides the 50 MHz system clock by a runtime-programmable period, with a programmable high time (duty cycle) and a one-cycle tick strobe per period. Period and duty updates are glitch-free: they take effect only at a period boundary. A common sync input phase-aligns all channels.

## Interface
- N, 2, number of channels (1..16)
- W, 32, counter/period width in bits
- DEF_DIV, 50_000, reset period in clk cycles for every channel (1 kHz at 50 MHz)
- DEF_HIGH, 25_000, reset high time in clk cycles for every channel
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  N  per-channel run enable
- sync  in  1  restart all channels at count 0 (phase alignment)
- wr_en  in  1  shadow register write strobe
- wr_ch  in  max(1,clog2(N))  target channel; values >= N are ignored
- wr_div  in  W  new period
- wr_high  in  W  new high time
- clk_out  out  N  divided clock, registered
- tick  out  N  one-cycle strobe at each period start, registered
- upd_pending  out  N  shadow written but not yet applied

## Operation
- Per channel: shadow_div/shadow_high (written by the port), active_div/active_high (used by the counter), counter cnt[W-1:0].
- Reset: cnt=0, shadow and active = DEF_DIV/DEF_HIGH, clk_out=0, tick=0, upd_pending=0.
- Write: wr_en with valid wr_ch loads that channel's shadows and sets upd_pending. No other channel is affected.
- Running (en=1, active_div>=1): if cnt==active_div-1, then cnt<=0, active<=shadow, upd_pending<=0, tick<=1; otherwise cnt<=cnt+1, tick<=0.
- clk_out<=(cnt_next < high_next), where next values are post-update. Consequences:
  - active_high==0 gives constant 0.
  - active_high>=active_div gives constant 1.
- active_div==1: tick on every cycle; clk_out=(high!=0).
- active_div==0: channel stopped. cnt=0, clk_out=0, tick=0. active<=shadow each cycle, so a nonzero write restarts the channel.
- en=0: cnt held 0, clk_out=0, tick=0, active<=shadow each cycle, upd_pending<=0. On the first en=1 cycle, counting resumes from 0 normally. No tick is issued until the first wrap.
- sync=1 (all channels, any en): cnt<=0, active<=shadow, upd_pending<=0, tick<=en[i], clk_out<=en[i] & (0<high_next).
- Priority: rst > sync > en=0 > wrap > count.
- Write in the same cycle as a wrap or sync: the wrap/sync loads the old shadow. The new value lands in the shadow, upd_pending=1, and the value applies at the following wrap.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Write to effect: the applied period begins on the cycle after the next wrap. Worst-case latency is one full old period plus 1 cycle.
- The tick strobe coincides with the first clk_out cycle of a period (cnt==0).
- Output period is active_div cycles. High time is active_high cycles, starting at cnt==0.
- rst mid-period: all state returns to reset values immediately (asynchronous).
- No runt pulses: clk_out never changes width within a period, including across updates.

## Structure
- Package clk_gen_pkg:
  - CLK_FREQ=50_000_000
  - default DEF_DIV/DEF_HIGH
  - function freq_to_div(freq) = CLK_FREQ/freq
- Sub-module clk_gen_channel: one channel (shadow, active, counter, output registers).
  - Top level: generate loop of N instances, plus write-address decode and sync fan-out.

## Test plan
- Bench params N=2, W=8, DEF_DIV=4, DEF_HIGH=2.
- Reset release with en=2'b11: after first wrap, each clk_out repeats 1,1,0,0; tick is high once every 4 cycles, aligned with the first 1.
- Write ch1 div=6 high=1 mid-period: upd_pending[1]=1; the current 4-cycle period completes; then clk_out[1] = 1,0,0,0,0,0 and upd_pending clears at the wrap. ch0 is unchanged.
- Write coincident with a ch0 wrap (div=3): the next period is still 4; the period after is 3.
- high=0 gives clk_out stuck at 0 with ticks still every period. high=9, div=4 gives clk_out stuck at 1. div=1 gives tick every cycle. div=0 gives channel idle; then writing div=5 restarts it with period 5.
- Channels with different periods (4 and 6), assert sync for 1 cycle: both ticks fire on the next cycle and remain aligned every 12 cycles.
- Assert rst mid-period and during upd_pending: all outputs are 0 immediately, and shadows revert to 4/2. Deassert en[0]: clk_out[0]=0 within 1 cycle; re-enable gives the first tick after 4 cycles.
